// File: rtl/alu_execute_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_execute_stage_pkg
//   Shared MIPS ALU control encodings (the mips.h constants) used by both the
//   decode-stage ALU control and the execute stage, plus the EX/MEM register
//   layout and datapath constants.
// -----------------------------------------------------------------------------
package alu_execute_stage_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;
  localparam int REG_IDX_W  = 5;
  localparam int SHAMT_W    = 5;

  // ALU operation codes. Code 0 is the nop used for SYSCALL/JR; any code not
  // listed here is treated as undefined by the execute stage.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_nop   = 4'd0,
    ALU_add   = 4'd1,
    ALU_sub   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_sll   = 4'd4,
    ALU_sra   = 4'd5,
    ALU_slli  = 4'd6,
    ALU_undef = 4'd7
  } alu_op_e;

  // EX/MEM pipeline register contents.
  typedef struct packed {
    logic                  valid;
    logic [ALU_DATA_W-1:0] result;
    logic                  zero;
    logic                  overflow;
    logic                  undef_op;
    logic [REG_IDX_W-1:0]  dest;
  } ex_mem_t;

  // Bubble: an empty slot that never writes back and never raises a fault.
  function automatic ex_mem_t ex_mem_bubble();
    ex_mem_t b;
    b = '0;
    return b;
  endfunction

endpackage : alu_execute_stage_pkg

// File: rtl/alu_execute_stage_alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU operation table for the execute stage.
//   Ports:
//     alu_op   - operation code (alu_execute_stage_pkg encodings)
//     a, b     - rs operand / rt-or-immediate operand
//     shamt    - shift amount for sll/sra
//     trap_ovf - enables the signed-overflow trap for add
//     y        - raw result (carries discarded)
//     ovf      - signed add overflow with trapping enabled
//     undef    - alu_op is ALU_undef or an unlisted code
// -----------------------------------------------------------------------------
module alu_core
  import alu_execute_stage_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 16
) (
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic                trap_ovf,
  output logic [WIDTH-1:0]    y,
  output logic                ovf,
  output logic                undef
);

  logic [WIDTH-1:0] sum;

  assign sum = a + b;

  always_comb begin
    y     = '0;
    ovf   = 1'b0;
    undef = 1'b0;
    case (alu_op)
      ALU_nop:  y = '0;
      ALU_add: begin
        y   = sum;
        // Same-sign operands producing a different-sign sum; sub never traps.
        ovf = trap_ovf && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_sub:  y = a - b;
      ALU_OR:   y = a | b;
      ALU_sll:  y = b << shamt;
      ALU_sra:  y = $unsigned($signed(b) >>> shamt);
      ALU_slli: y = b << LUI_SHIFT;
      default:  undef = 1'b1;
    endcase
  end

endmodule : alu_core

// File: rtl/alu_execute_stage.sv
// -----------------------------------------------------------------------------
// alu_execute_stage
//   EX stage: runs the ALU on the ID/EX operands and captures result, flags and
//   destination into the EX/MEM register with one cycle of latency.
//   Ports:
//     clk, rst        - clock; asynchronous active-high reset
//     stall, flush    - hazard unit controls (flush has priority over stall)
//     in_valid        - ID/EX holds a real instruction
//     alu_op, src_a, src_b, shamt, trap_ovf, dest_in - ID/EX inputs
//     out_valid, result, zero, overflow, undef_op, dest_out - EX/MEM outputs
//   Handshake: no backpressure. An instruction with in_valid=1 is captured on
//   any rising edge without stall/flush and appears with out_valid=1 one cycle
//   later; stall freezes EX/MEM, flush replaces it with a bubble.
// -----------------------------------------------------------------------------
module alu_execute_stage
  import alu_execute_stage_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [ALU_OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic [SHAMT_W-1:0]   shamt,
  input  logic                 trap_ovf,
  input  logic [REG_IDX_W-1:0] dest_in,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 overflow,
  output logic                 undef_op,
  output logic [REG_IDX_W-1:0] dest_out
);

  logic [WIDTH-1:0] alu_y;
  logic             alu_ovf;
  logic             alu_undef;

  ex_mem_t ex_mem_d;
  ex_mem_t ex_mem_q;

  alu_core #(
    .WIDTH     (WIDTH),
    .LUI_SHIFT (LUI_SHIFT)
  ) u_alu_core (
    .alu_op   (alu_op),
    .a        (src_a),
    .b        (src_b),
    .shamt    (shamt),
    .trap_ovf (trap_ovf),
    .y        (alu_y),
    .ovf      (alu_ovf),
    .undef    (alu_undef)
  );

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (flush) begin
      ex_mem_d = ex_mem_bubble();
    end else if (stall) begin
      ex_mem_d = ex_mem_q;
    end else if (!in_valid) begin
      ex_mem_d = ex_mem_bubble();
    end else begin
      ex_mem_d.valid    = 1'b1;
      ex_mem_d.overflow = alu_ovf;
      ex_mem_d.undef_op = alu_undef;
      if (alu_ovf || alu_undef) begin
        // Faulting instruction: drop the result and suppress writeback.
        ex_mem_d.result = '0;
        ex_mem_d.dest   = '0;
      end else begin
        ex_mem_d.result = alu_y;
        ex_mem_d.dest   = dest_in;
      end
      // Derived from the value being loaded, not from the stale register.
      ex_mem_d.zero = (ex_mem_d.result == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_q <= ex_mem_bubble();
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign out_valid = ex_mem_q.valid;
  assign result    = ex_mem_q.result;
  assign zero      = ex_mem_q.zero;
  assign overflow  = ex_mem_q.overflow;
  assign undef_op  = ex_mem_q.undef_op;
  assign dest_out  = ex_mem_q.dest;

endmodule : alu_execute_stage

// File: tb/tb_alu_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_execute_stage
//   Directed scoreboard bench for alu_execute_stage. The driver pushes the
//   hand-computed EX/MEM contents expected after each clock edge; a monitor
//   pops and compares one entry after every rising edge.
// -----------------------------------------------------------------------------
module tb_alu_execute_stage;
  import alu_execute_stage_pkg::*;

  localparam int EXP_W = 1 + 32 + 1 + 1 + 1 + 5;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic        trap_ovf = 1'b0;
  logic [4:0]  dest_in = '0;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        undef_op;
  logic [4:0]  dest_out;

  alu_execute_stage #(.WIDTH(32), .LUI_SHIFT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .shamt     (shamt),
    .trap_ovf  (trap_ovf),
    .dest_in   (dest_in),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .undef_op  (undef_op),
    .dest_out  (dest_out)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] last_exp;
  string            name_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  function automatic logic [EXP_W-1:0] pack(input logic v, input logic [31:0] r,
                                            input logic z, input logic o,
                                            input logic u, input logic [4:0] d);
    return {v, r, z, o, u, d};
  endfunction

  function automatic logic [EXP_W-1:0] dut_vec();
    return {out_valid, result, zero, overflow, undef_op, dest_out};
  endfunction

  task automatic check(input string nm, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%0b res=%08h z=%0b ovf=%0b und=%0b dst=%0d, want v=%0b res=%08h z=%0b ovf=%0b und=%0b dst=%0d",
               nm, act[40], act[39:8], act[7], act[6], act[5], act[4:0],
               exp[40], exp[39:8], exp[7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  // Monitor: one expected entry per rising edge while the queue is non-empty.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      string            nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, dut_vec(), e);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input string nm, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic tr, input logic [4:0] d,
                       input logic st, input logic fl, input logic [EXP_W-1:0] e);
    @(negedge clk);
    in_valid = v; alu_op = op; src_a = a; src_b = b; shamt = sh;
    trap_ovf = tr; dest_in = d; stall = st; flush = fl;
    exp_q.push_back(e);
    name_q.push_back(nm);
    last_exp = e;
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [EXP_W-1:0] bub;
    bub = '0;
    last_exp = '0;

    // Reset values while reset is held.
    #2;
    check("reset_values", dut_vec(), bub);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    drive("add_ovf_trap", 1, ALU_add, 32'h7FFF_FFFF, 32'h1, 5'd0, 1, 5'd8, 0, 0,
          pack(1, 32'h0, 1, 1, 0, 5'd0));
    drive("add_no_trap", 1, ALU_add, 32'h7FFF_FFFF, 32'h1, 5'd0, 0, 5'd8, 0, 0,
          pack(1, 32'h8000_0000, 0, 0, 0, 5'd8));
    drive("add_plain", 1, ALU_add, 32'd3, 32'd4, 5'd0, 1, 5'd5, 0, 0,
          pack(1, 32'd7, 0, 0, 0, 5'd5));
    drive("add_neg_ovf", 1, ALU_add, 32'h8000_0000, 32'h8000_0000, 5'd0, 1, 5'd6, 0, 0,
          pack(1, 32'h0, 1, 1, 0, 5'd0));
    drive("sra", 1, ALU_sra, 32'h0, 32'h8000_0010, 5'd4, 0, 5'd9, 0, 0,
          pack(1, 32'hF800_0001, 0, 0, 0, 5'd9));
    drive("slli", 1, ALU_slli, 32'h0, 32'h0000_1234, 5'd7, 0, 5'd10, 0, 0,
          pack(1, 32'h1234_0000, 0, 0, 0, 5'd10));
    drive("sll_31", 1, ALU_sll, 32'h0, 32'h3, 5'd31, 0, 5'd2, 0, 0,
          pack(1, 32'h8000_0000, 0, 0, 0, 5'd2));
    drive("sub_zero", 1, ALU_sub, 32'd5, 32'd5, 5'd0, 1, 5'd11, 0, 0,
          pack(1, 32'h0, 1, 0, 0, 5'd11));
    drive("sub_wrap_no_trap", 1, ALU_sub, 32'h8000_0000, 32'h1, 5'd0, 1, 5'd13, 0, 0,
          pack(1, 32'h7FFF_FFFF, 0, 0, 0, 5'd13));
    drive("or", 1, ALU_OR, 32'h0000_FF00, 32'h0000_00FF, 5'd0, 0, 5'd12, 0, 0,
          pack(1, 32'h0000_FFFF, 0, 0, 0, 5'd12));
    for (int i = 0; i < 3; i++) begin
      drive("stall_hold", 1, ALU_add, 32'd100 + i, 32'd7, 5'd0, 0, 5'd20 + 5'(i), 1, 0,
            last_exp);
    end
    drive("stall_flush", 1, ALU_add, 32'd1, 32'd1, 5'd0, 0, 5'd4, 1, 1, bub);
    drive("undef_op", 1, ALU_undef, 32'd1, 32'd2, 5'd0, 0, 5'd3, 0, 0,
          pack(1, 32'h0, 1, 0, 1, 5'd0));
    drive("undef_stalled", 1, ALU_add, 32'd1, 32'd2, 5'd0, 0, 5'd3, 1, 0,
          last_exp);
    drive("op15", 1, 4'd15, 32'd1, 32'd2, 5'd0, 0, 5'd3, 0, 0,
          pack(1, 32'h0, 1, 0, 1, 5'd0));
    drive("undef_invalid", 0, ALU_undef, 32'd1, 32'd2, 5'd0, 0, 5'd3, 0, 0, bub);
    drive("nop", 1, ALU_nop, 32'hDEAD_BEEF, 32'h1, 5'd3, 0, 5'd31, 0, 0,
          pack(1, 32'h0, 1, 0, 0, 5'd31));
    drive("or_again", 1, ALU_OR, 32'h1, 32'h2, 5'd0, 0, 5'd7, 0, 0,
          pack(1, 32'h3, 0, 0, 0, 5'd7));
    drive("flush_only", 1, ALU_OR, 32'h1, 32'h2, 5'd0, 0, 5'd7, 0, 1, bub);

    // Asynchronous reset mid-cycle with an add in EX/MEM.
    drive("pre_reset_add", 1, ALU_add, 32'd10, 32'd20, 5'd0, 1, 5'd14, 0, 0,
          pack(1, 32'd30, 0, 0, 0, 5'd14));
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", dut_vec(), bub);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive("post_reset_sub", 1, ALU_sub, 32'd9, 32'd4, 5'd0, 0, 5'd1, 0, 0,
          pack(1, 32'd5, 0, 0, 0, 5'd1));
    idle_inputs();

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_execute_stage
